logic_unit_arbiter_16: RTL and testbench

//   Shares one 16-bit bitwise logic unit (AND/OR/XOR/NOR) between two requesters.

---
 rtl/logic_unit_arbiter_16.sv | 148 ++++++++++++++
 tb/tb_logic_unit_arbiter_16.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter_16.sv
// Round-robin arbiter sharing one 16-bit AND/OR/XOR/NOR unit between two requesters.
// Define LOGIC_ARB_STATS_EN to add saturating per-requester grant counters.
module logic_unit_arbiter_16 #(
    parameter int W = 16
`ifdef LOGIC_ARB_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_req_0,
    input  logic             i_req_1,
    input  logic [1:0]       i_op_0,
    input  logic [1:0]       i_op_1,
    input  logic [W-1:0]     i_a_0,
    input  logic [W-1:0]     i_a_1,
    input  logic [W-1:0]     i_b_0,
    input  logic [W-1:0]     i_b_1,
    output logic             o_gnt_0,
    output logic             o_gnt_1,
    output logic             o_done_0,
    output logic             o_done_1,
    output logic [W-1:0]     o_result,
    output logic             o_busy
`ifdef LOGIC_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] o_gnt_cnt_0,
    output logic [CNT_W-1:0] o_gnt_cnt_1
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]   r_state;
    logic         r_owner;
    logic         r_last_owner;
    logic [1:0]   r_op;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [W-1:0] r_result;
    logic         r_gnt_0;
    logic         r_gnt_1;
    logic         r_done_0;
    logic         r_done_1;

    logic         w_any_req;
    logic         w_pick_1;
    logic [W-1:0] w_func;

    // Requester 1 wins when alone, or when both ask and 0 was served last.
    assign w_any_req = i_req_0 | i_req_1;
    assign w_pick_1  = i_req_1 & (~i_req_0 | ~r_last_owner);

    always_comb begin
        w_func = '0;
        case (r_op)
            2'b00:   w_func = r_a & r_b;
            2'b01:   w_func = r_a | r_b;
            2'b10:   w_func = r_a ^ r_b;
            default: w_func = ~(r_a | r_b);
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_op         <= 2'b00;
            r_a          <= '0;
            r_b          <= '0;
            r_result     <= '0;
            r_gnt_0      <= 1'b0;
            r_gnt_1      <= 1'b0;
            r_done_0     <= 1'b0;
            r_done_1     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done_0 <= 1'b0;
                    r_done_1 <= 1'b0;
                    if (w_any_req) begin
                        r_owner <= w_pick_1;
                        r_op    <= w_pick_1 ? i_op_1 : i_op_0;
                        r_a     <= w_pick_1 ? i_a_1  : i_a_0;
                        r_b     <= w_pick_1 ? i_b_1  : i_b_0;
                        r_gnt_0 <= ~w_pick_1;
                        r_gnt_1 <= w_pick_1;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_result <= w_func;
                    r_done_0 <= ~r_owner;
                    r_done_1 <= r_owner;
                    r_state  <= ST_RESP;
                end
                ST_RESP: begin
                    r_last_owner <= r_owner;
                    r_gnt_0      <= 1'b0;
                    r_gnt_1      <= 1'b0;
                    r_done_0     <= 1'b0;
                    r_done_1     <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_gnt_0  <= 1'b0;
                    r_gnt_1  <= 1'b0;
                    r_done_0 <= 1'b0;
                    r_done_1 <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_gnt_0  = r_gnt_0;
    assign o_gnt_1  = r_gnt_1;
    assign o_done_0 = r_done_0;
    assign o_done_1 = r_done_1;
    assign o_result = r_result;
    assign o_busy   = (r_state != ST_IDLE);

`ifdef LOGIC_ARB_STATS_EN
    logic [CNT_W-1:0] r_gnt_cnt_0;
    logic [CNT_W-1:0] r_gnt_cnt_1;

    // Counters bump once per completed operation and stick at all-ones.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_gnt_cnt_0 <= '0;
            r_gnt_cnt_1 <= '0;
        end else if (r_state == ST_RESP) begin
            if (!r_owner && (r_gnt_cnt_0 != {CNT_W{1'b1}}))
                r_gnt_cnt_0 <= r_gnt_cnt_0 + 1'b1;
            if (r_owner && (r_gnt_cnt_1 != {CNT_W{1'b1}}))
                r_gnt_cnt_1 <= r_gnt_cnt_1 + 1'b1;
        end
    end

    assign o_gnt_cnt_0 = r_gnt_cnt_0;
    assign o_gnt_cnt_1 = r_gnt_cnt_1;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter_16.sv
// Self-checking bench for logic_unit_arbiter_16: directed cases plus random traffic
// against a transaction-level model. Checks grant counters when LOGIC_ARB_STATS_EN is defined.
module tb_logic_unit_arbiter_16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_0, req_1;
    logic [1:0]  op_0, op_1;
    logic [15:0] a_0, a_1, b_0, b_1;
    logic        gnt_0, gnt_1, done_0, done_1, busy;
    logic [15:0] result;
`ifdef LOGIC_ARB_STATS_EN
    logic [15:0] gnt_cnt_0, gnt_cnt_1;
`endif

    int          n_checks = 0;
    int          n_err    = 0;
    logic        exp_last;
    logic [15:0] exp_result;
    int          exp_cnt0, exp_cnt1;

    always #5 clk = ~clk;

    logic_unit_arbiter_16 dut (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_req_0  (req_0),
        .i_req_1  (req_1),
        .i_op_0   (op_0),
        .i_op_1   (op_1),
        .i_a_0    (a_0),
        .i_a_1    (a_1),
        .i_b_0    (b_0),
        .i_b_1    (b_1),
        .o_gnt_0  (gnt_0),
        .o_gnt_1  (gnt_1),
        .o_done_0 (done_0),
        .o_done_1 (done_1),
        .o_result (result),
        .o_busy   (busy)
`ifdef LOGIC_ARB_STATS_EN
        ,
        .o_gnt_cnt_0 (gnt_cnt_0),
        .o_gnt_cnt_1 (gnt_cnt_1)
`endif
    );

    function automatic logic [15:0] ref_f(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one operation starting from an idle negedge; ends on the negedge after RESP.
    // mode 0: plain, 1: scramble operands during EXEC, 2: owner drops req during EXEC.
    task automatic do_op(input logic rq0, input logic rq1,
                         input logic [1:0] o0, input logic [15:0] x0, input logic [15:0] y0,
                         input logic [1:0] o1, input logic [15:0] x1, input logic [15:0] y1,
                         input int mode);
        logic owner;
        req_0 = rq0; op_0 = o0; a_0 = x0; b_0 = y0;
        req_1 = rq1; op_1 = o1; a_1 = x1; b_1 = y1;
        owner      = (rq0 && rq1) ? ~exp_last : rq1;
        exp_result = owner ? ref_f(o1, x1, y1) : ref_f(o0, x0, y0);
        @(negedge clk);
        chk1("exec_gnt_0", gnt_0, ~owner);
        chk1("exec_gnt_1", gnt_1, owner);
        chk1("exec_done_0", done_0, 1'b0);
        chk1("exec_done_1", done_1, 1'b0);
        chk1("exec_busy", busy, 1'b1);
        if (mode == 1) begin
            a_0 = 16'hFFFF; a_1 = 16'hFFFF; b_0 = ~y0; b_1 = ~y1; op_0 = ~o0; op_1 = ~o1;
        end
        if (mode == 2) begin
            if (owner) req_1 = 1'b0; else req_0 = 1'b0;
        end
        @(negedge clk);
        chk1("resp_done_0", done_0, ~owner);
        chk1("resp_done_1", done_1, owner);
        chk1("resp_gnt_0", gnt_0, ~owner);
        chk1("resp_gnt_1", gnt_1, owner);
        chk16("resp_result", result, exp_result);
        if (owner) req_1 = 1'b0; else req_0 = 1'b0;
        exp_last = owner;
        if (owner) exp_cnt1++; else exp_cnt0++;
        @(negedge clk);
        chk1("idle_done_0", done_0, 1'b0);
        chk1("idle_done_1", done_1, 1'b0);
        chk1("idle_gnt_0", gnt_0, 1'b0);
        chk1("idle_gnt_1", gnt_1, 1'b0);
        chk1("idle_busy", busy, 1'b0);
        chk16("idle_result_hold", result, exp_result);
    endtask

    initial begin
        reset = 1'b1;
        req_0 = 1'b0; req_1 = 1'b0;
        op_0 = 2'b00; op_1 = 2'b00;
        a_0 = 16'h0; a_1 = 16'h0; b_0 = 16'h0; b_1 = 16'h0;
        exp_last = 1'b1; exp_result = 16'h0; exp_cnt0 = 0; exp_cnt1 = 0;

        repeat (2) @(negedge clk);
        chk16("rst_result", result, 16'h0000);
        chk1("rst_gnt_0", gnt_0, 1'b0);
        chk1("rst_gnt_1", gnt_1, 1'b0);
        chk1("rst_done_0", done_0, 1'b0);
        chk1("rst_done_1", done_1, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        reset = 1'b0;

        do_op(1'b1, 1'b0, 2'b01, 16'hF0F0, 16'h0F0F, 2'b00, 16'h0, 16'h0, 0);
        chk16("or_ffff", result, 16'hFFFF);
        do_op(1'b0, 1'b1, 2'b00, 16'h0, 16'h0, 2'b11, 16'h00FF, 16'h0F00, 0);
        chk16("nor_f000", result, 16'hF000);

        for (int i = 0; i < 4; i++) begin
            do_op(1'b1, 1'b1, 2'b00, 16'hFFFF, 16'h1234, 2'b10, 16'hAAAA, 16'hFFFF, 0);
            chk16("alt_result", result, (i % 2 == 0) ? 16'h1234 : 16'h5555);
        end
        req_0 = 1'b0; req_1 = 1'b0;

        repeat (3) begin
            @(negedge clk);
            chk1("noreq_busy", busy, 1'b0);
            chk1("noreq_done_0", done_0, 1'b0);
            chk16("noreq_result", result, exp_result);
        end

        do_op(1'b1, 1'b0, 2'b01, 16'h1111, 16'h0000, 2'b00, 16'h0, 16'h0, 1);
        chk16("operand_latched", result, 16'h1111);
        do_op(1'b1, 1'b0, 2'b10, 16'h0F0F, 16'h00FF, 2'b00, 16'h0, 16'h0, 2);
        do_op(1'b0, 1'b1, 2'b00, 16'h0, 16'h0, 2'b00, 16'hC3C3, 16'h0FF0, 2);

        // Abort mid-EXEC: no done, outputs back to reset values, round-robin pointer reset.
        req_0 = 1'b1; op_0 = 2'b01; a_0 = 16'h1357; b_0 = 16'h0000;
        @(negedge clk);
        chk1("abort_busy_exec", busy, 1'b1);
        reset = 1'b1;
        req_0 = 1'b0;
        @(negedge clk);
        chk1("abort_done_0", done_0, 1'b0);
        chk1("abort_gnt_0", gnt_0, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        chk16("abort_result", result, 16'h0000);
        reset = 1'b0;
        exp_last = 1'b1; exp_result = 16'h0; exp_cnt0 = 0; exp_cnt1 = 0;
        @(negedge clk);
        chk1("abort_no_late_done", done_0, 1'b0);
        do_op(1'b1, 1'b1, 2'b10, 16'h00F0, 16'h0FF0, 2'b01, 16'h1, 16'h2, 0);
        chk16("post_reset_owner0", result, 16'h0F00);
        req_0 = 1'b0; req_1 = 1'b0;

        for (int i = 0; i < 30; i++) begin
            int pat;
            pat = int'($urandom_range(1, 3));
            do_op(pat[0], pat[1],
                  2'($urandom), 16'($urandom), 16'($urandom),
                  2'($urandom), 16'($urandom), 16'($urandom),
                  int'($urandom_range(0, 2)));
            if ($urandom_range(0, 3) == 0) begin
                req_0 = 1'b0; req_1 = 1'b0;
                repeat (int'($urandom_range(1, 3))) begin
                    @(negedge clk);
                    chk1("gap_busy", busy, 1'b0);
                    chk16("gap_result", result, exp_result);
                end
            end
        end
        req_0 = 1'b0; req_1 = 1'b0;
        @(negedge clk);

`ifdef LOGIC_ARB_STATS_EN
        chk16("gnt_cnt_0", gnt_cnt_0, 16'(exp_cnt0));
        chk16("gnt_cnt_1", gnt_cnt_1, 16'(exp_cnt1));
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
